// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared encodings and helpers for the iterative multiplier
//
// Purpose: op encodings, FSM state encoding, operand signedness helpers and
// the decoder's M-extension funct3 to multiplier-op mapping.
// Ports: none (package).

package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_e;

  function automatic logic op_a_signed(input logic [1:0] op);
    return (op != MUL_OP_MULHU);
  endfunction

  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

  // RV32M multiply funct3 values 000..011 line up with the op encoding above;
  // the decoder only calls this for the multiply group.
  function automatic logic [1:0] mul_op_from_alu_op(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/mul_sign_prep.sv
// rtl/mul_sign_prep.sv - operand magnitude and result sign for mul/div
//
// Purpose: combinational conversion of both operands to unsigned magnitudes
// and computation of the final product/quotient sign from the op.
// Ports:
//   op_i        in  2     multiplier op encoding
//   operand_a_i in  XLEN  rs1 value
//   operand_b_i in  XLEN  rs2 value
//   mag_a_o     out XLEN  |a| (a treated as signed only when the op says so)
//   mag_b_o     out XLEN  |b|
//   neg_o       out 1     final result must be negated

module mul_sign_prep
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            neg_o
);

  logic a_neg;
  logic b_neg;

  assign a_neg = op_a_signed(op_i) & operand_a_i[XLEN-1];
  assign b_neg = op_b_signed(op_i) & operand_b_i[XLEN-1];

  // Two's complement negation of the most negative value wraps to itself,
  // which read as unsigned is exactly 2^(XLEN-1).
  assign mag_a_o = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
  assign mag_b_o = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;
  assign neg_o   = a_neg ^ b_neg;

endmodule

// File: rtl/mul_iter_unit.sv
// rtl/mul_iter_unit.sv - iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU)
//
// Purpose: shift-add multiply on operand magnitudes, BPC bits of B per cycle,
// followed by one sign-fix cycle. Valid/ready on both sides, flushable.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        kill any in-flight operation
//   in_valid_i     operation request
//   in_ready_o     unit can accept an operation
//   op_i           00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   operand_a_i    rs1 value
//   operand_b_i    rs2 value
//   tag_i          sideband tag, returned unchanged
//   out_valid_o    result available
//   out_ready_i    consumer takes result
//   result_o       selected half of the product
//   tag_o          tag of the returned result
//   busy_o         state is not IDLE

module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BPC   = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  operand_a_i,
  input  logic [XLEN-1:0]  operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int ITER  = XLEN / BPC;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam int PW    = 2 * XLEN;

  mul_state_e       state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mag_a_q, mag_a_d;   // |a| pre-shifted to the current digit position
  logic [XLEN-1:0]  b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [1:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic [XLEN-1:0]  prep_mag_a;
  logic [XLEN-1:0]  prep_mag_b;
  logic             prep_neg;
  logic             accept;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    product;

  mul_sign_prep #(
    .XLEN (XLEN)
  ) u_sign_prep (
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .mag_a_o     (prep_mag_a),
    .mag_b_o     (prep_mag_b),
    .neg_o       (prep_neg)
  );

  assign in_ready_o  = (state_q == ST_IDLE) && !flush_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign result_o    = result_q;
  assign tag_o       = tag_q;

  // mag_a * B[BPC-1:0] as a sum of shifted copies; mag_a_q already carries
  // the digit's weight, so no extra positional shift is needed here.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BPC; i++) begin
      if (b_q[i]) begin
        partial = partial + (mag_a_q << i);
      end
    end
  end

  assign product = neg_q ? (~acc_q + 1'b1) : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mag_a_d  = mag_a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    tag_d    = tag_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d    = op_i;
            tag_d   = tag_i;
            neg_d   = prep_neg;
            acc_d   = '0;
            mag_a_d = {{XLEN{1'b0}}, prep_mag_a};
            b_d     = prep_mag_b;
            cnt_d   = CNT_W'(ITER);
            // Zero operand: product is zero whatever the sign, skip the loop.
            if (operand_a_i == '0 || operand_b_i == '0) begin
              result_d = '0;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc_d   = acc_q + partial;
          mag_a_d = mag_a_q << BPC;
          b_d     = b_q >> BPC;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          result_d = (op_q == MUL_OP_MUL) ? product[XLEN-1:0] : product[PW-1:XLEN];
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mag_a_q  <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= MUL_OP_MUL;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mag_a_q  <= mag_a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

endmodule
